// File: rtl/spi_pkg.sv
// Shared types and width helpers for the passive SPI bus observer.
package spi_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   typedef struct packed {
      logic cpol;
      logic cphase;
      logic msb_first;
   } mode_t;

   // Counter must be able to hold the value DATA_WIDTH itself.
   function automatic int cnt_width(input int data_width);
      return $clog2(data_width) + 1;
   endfunction

   function automatic int sel_width(input int slaves);
      return (slaves > 1) ? $clog2(slaves) : 1;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage multi-bit synchroniser; every stage resets to 0.
module spi_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] ff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_intf.sv
// Passive SPI observer: synchronises the pins, finds CPOL/CPHA sample edges,
// deserialises MOSI/MISO into words and flags framing / chip-select errors.
module spi_intf
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int NO_OF_SLAVES = 1,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                                 pclk,
   input  logic                                 areset,
   input  logic                                 cpol,
   input  logic                                 cphase,
   input  logic                                 msb_first,
   input  logic                                 sclk,
   input  logic [NO_OF_SLAVES-1:0]              cs_n,
   input  logic                                 mosi,
   input  logic                                 miso,
   output logic                                 frame_active,
   output logic [sel_width(NO_OF_SLAVES)-1:0]   slave_sel,
   output logic                                 rx_valid,
   output logic [DATA_WIDTH-1:0]                mosi_data,
   output logic [DATA_WIDTH-1:0]                miso_data,
   output logic [cnt_width(DATA_WIDTH)-1:0]     bit_count,
   output logic                                 frame_err,
   output logic                                 multi_sel_err
);

   localparam int CNT_W = cnt_width(DATA_WIDTH);
   localparam int SEL_W = sel_width(NO_OF_SLAVES);
   localparam int LOW_W = $clog2(NO_OF_SLAVES + 1);
   localparam int SYN_W = NO_OF_SLAVES + 3;

   logic [SYN_W-1:0]        sync_q;
   logic                    sclk_s;
   logic                    mosi_s;
   logic                    miso_s;
   logic [NO_OF_SLAVES-1:0] cs_s;
   logic                    sclk_d;

   spi_sync #(
      .WIDTH  (SYN_W),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (pclk),
      .rst (areset),
      .d   ({sclk, mosi, miso, cs_n}),
      .q   (sync_q)
   );

   assign {sclk_s, mosi_s, miso_s, cs_s} = sync_q;

   state_e                  state;
   state_e                  state_next;
   mode_t                   mode_q;
   logic [LOW_W-1:0]        low_cnt;
   logic [SEL_W-1:0]        sel_idx;
   logic                    one_low;
   logic                    multi;
   logic                    all_high;
   logic                    rise;
   logic                    fall;
   logic                    leading;
   logic                    trailing;
   logic                    sample_edge;
   logic                    start;
   logic                    shift_en;
   logic                    word_last;
   logic                    release_err;
   logic                    cs_seen_high;
   logic                    multi_d;
   logic                    word_done_p1;
   logic [DATA_WIDTH-1:0]   mosi_shift;
   logic [DATA_WIDTH-1:0]   miso_shift;
   logic [DATA_WIDTH-1:0]   mosi_next;
   logic [DATA_WIDTH-1:0]   miso_next;

   always_comb begin
      low_cnt = '0;
      sel_idx = '0;
      for (int i = 0; i < NO_OF_SLAVES; i++) begin
         low_cnt = low_cnt + LOW_W'(~cs_s[i]);
      end
      for (int i = NO_OF_SLAVES - 1; i >= 0; i--) begin
         if (!cs_s[i]) sel_idx = SEL_W'(i);
      end
   end

   assign one_low  = (low_cnt == LOW_W'(1));
   assign multi    = (low_cnt >  LOW_W'(1));
   assign all_high = (low_cnt == '0);

   // Edge qualification uses the mode latched at frame start.
   assign rise        = sclk_s & ~sclk_d;
   assign fall        = ~sclk_s & sclk_d;
   assign leading     = mode_q.cpol ? fall : rise;
   assign trailing    = mode_q.cpol ? rise : fall;
   assign sample_edge = mode_q.cphase ? trailing : leading;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (one_low && cs_seen_high) state_next = ACTIVE;
         ACTIVE:  if (!one_low)                state_next = IDLE;
         default:                              state_next = IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge areset) begin
      if (areset) state <= IDLE;
      else        state <= state_next;
   end

   // A CS release or multi-select in the same cycle as an edge suppresses the shift.
   assign start       = (state == IDLE)   && (state_next == ACTIVE);
   assign shift_en    = (state == ACTIVE) && (state_next == ACTIVE) && sample_edge;
   assign word_last   = (bit_count == CNT_W'(DATA_WIDTH - 1));
   assign release_err = (state == ACTIVE) && all_high && (bit_count != '0);

   assign mosi_next = mode_q.msb_first ? {mosi_shift[DATA_WIDTH-2:0], mosi_s}
                                       : {mosi_s, mosi_shift[DATA_WIDTH-1:1]};
   assign miso_next = mode_q.msb_first ? {miso_shift[DATA_WIDTH-2:0], miso_s}
                                       : {miso_s, miso_shift[DATA_WIDTH-1:1]};

   // multi_d resets high so the all-zero synchroniser contents after reset
   // are not reported as a multi-select.
   always_ff @(posedge pclk or posedge areset) begin
      if (areset) begin
         sclk_d        <= 1'b0;
         mode_q        <= '0;
         cs_seen_high  <= 1'b0;
         multi_d       <= 1'b1;
         frame_active  <= 1'b0;
         slave_sel     <= '0;
         bit_count     <= '0;
         mosi_shift    <= '0;
         miso_shift    <= '0;
         word_done_p1  <= 1'b0;
         rx_valid      <= 1'b0;
         mosi_data     <= '0;
         miso_data     <= '0;
         frame_err     <= 1'b0;
         multi_sel_err <= 1'b0;
      end else begin
         sclk_d        <= sclk_s;
         frame_active  <= (state_next == ACTIVE);
         multi_d       <= multi;
         multi_sel_err <= multi & ~multi_d;
         frame_err     <= release_err;

         if (all_high)   cs_seen_high <= 1'b1;
         else if (multi) cs_seen_high <= 1'b0;

         if (start) begin
            bit_count  <= '0;
            mosi_shift <= '0;
            miso_shift <= '0;
            slave_sel  <= sel_idx;
            mode_q     <= '{cpol: cpol, cphase: cphase, msb_first: msb_first};
         end else if (shift_en) begin
            mosi_shift <= mosi_next;
            miso_shift <= miso_next;
            bit_count  <= word_last ? '0 : bit_count + CNT_W'(1);
         end else if (state_next == IDLE) begin
            bit_count  <= '0;
         end

         // ---- word output stage: one cycle after the final shift ----
         word_done_p1 <= shift_en && word_last;
         rx_valid     <= word_done_p1;
         if (word_done_p1) begin
            mosi_data <= mosi_shift;
            miso_data <= miso_shift;
         end
      end
   end

endmodule

// File: tb/tb_spi_intf.sv
// Directed bench for spi_intf: drives an SPI master model and checks captured words and error flags.
module tb_spi_intf;

   logic       pclk = 1'b0;
   logic       areset;
   logic       cpol, cphase, msb_first;
   logic       sclk, mosi, miso;
   logic [3:0] cs_n;
   logic       frame_active;
   logic [1:0] slave_sel;
   logic       rx_valid;
   logic [7:0] mosi_data, miso_data;
   logic [3:0] bit_count;
   logic       frame_err, multi_sel_err;

   int tests  = 0;
   int failed = 0;

   int         rx_cnt   = 0;
   int         ferr_cnt = 0;
   int         merr_cnt = 0;
   logic [7:0] mosi_q[$];
   logic [7:0] miso_q[$];

   spi_intf #(
      .DATA_WIDTH   (8),
      .NO_OF_SLAVES (4),
      .SYNC_STAGES  (2)
   ) dut (
      .pclk          (pclk),
      .areset        (areset),
      .cpol          (cpol),
      .cphase        (cphase),
      .msb_first     (msb_first),
      .sclk          (sclk),
      .cs_n          (cs_n),
      .mosi          (mosi),
      .miso          (miso),
      .frame_active  (frame_active),
      .slave_sel     (slave_sel),
      .rx_valid      (rx_valid),
      .mosi_data     (mosi_data),
      .miso_data     (miso_data),
      .bit_count     (bit_count),
      .frame_err     (frame_err),
      .multi_sel_err (multi_sel_err)
   );

   always #5 pclk = ~pclk;

   // Pulse monitor, sampled on the inactive edge.
   always @(negedge pclk) begin
      if (rx_valid) begin
         rx_cnt++;
         mosi_q.push_back(mosi_data);
         miso_q.push_back(miso_data);
      end
      if (frame_err)     ferr_cnt++;
      if (multi_sel_err) merr_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic half();
      wait_cyc(4);
   endtask

   task automatic xfer(input logic [7:0] mo, input logic [7:0] mi, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         int b;
         b = msb_first ? 7 - i : i;
         if (!cphase) begin
            mosi = mo[b];
            miso = mi[b];
            half();
            sclk = ~cpol;
            half();
            sclk = cpol;
         end else begin
            sclk = ~cpol;
            mosi = mo[b];
            miso = mi[b];
            half();
            sclk = cpol;
            half();
         end
      end
   endtask

   task automatic set_mode(input logic p, input logic h, input logic m);
      cpol      = p;
      cphase    = h;
      msb_first = m;
      sclk      = p;
      wait_cyc(4);
   endtask

   int rb, fb, mb;

   initial begin
      areset = 1'b1;
      cpol = 1'b0; cphase = 1'b0; msb_first = 1'b1;
      sclk = 1'b0; mosi = 1'b0; miso = 1'b0; cs_n = 4'hF;
      wait_cyc(3);

      check("rst_frame_active", frame_active, 0);
      check("rst_rx_valid",     rx_valid,     0);
      check("rst_mosi_data",    mosi_data,    0);
      check("rst_bit_count",    bit_count,    0);
      check("rst_err_flags",    {frame_err, multi_sel_err}, 0);
      areset = 1'b0;
      wait_cyc(6);
      check("post_rst_no_merr", merr_cnt, 0);

      // Mode 0, MSB first, one byte
      rb = rx_cnt; fb = ferr_cnt;
      set_mode(1'b0, 1'b0, 1'b1);
      cs_n = 4'b1110;
      wait_cyc(4);
      check("m0_frame_active", frame_active, 1);
      check("m0_slave_sel",    slave_sel,    0);
      xfer(8'hA5, 8'h3C, 8);
      wait_cyc(4);
      cs_n = 4'hF;
      wait_cyc(8);
      check("m0_rx_count",  32'(rx_cnt - rb), 1);
      check("m0_mosi",      mosi_q[rb], 8'hA5);
      check("m0_miso",      miso_q[rb], 8'h3C);
      check("m0_frame_err", 32'(ferr_cnt - fb), 0);
      check("m0_held_data", mosi_data, 8'hA5);
      check("m0_frame_end", frame_active, 0);

      // Mode 3, LSB first, two bytes in one frame
      rb = rx_cnt; fb = ferr_cnt;
      set_mode(1'b1, 1'b1, 1'b0);
      cs_n = 4'b1110;
      wait_cyc(4);
      xfer(8'h01, 8'h5A, 8);
      xfer(8'h80, 8'hC3, 8);
      wait_cyc(4);
      cs_n = 4'hF;
      wait_cyc(8);
      check("m3_rx_count", 32'(rx_cnt - rb), 2);
      check("m3_mosi0",    mosi_q[rb],     8'h01);
      check("m3_mosi1",    mosi_q[rb + 1], 8'h80);
      check("m3_miso0",    miso_q[rb],     8'h5A);
      check("m3_miso1",    miso_q[rb + 1], 8'hC3);
      check("m3_frame_err", 32'(ferr_cnt - fb), 0);

      // Modes 1 and 2 with 0xF0
      rb = rx_cnt;
      set_mode(1'b0, 1'b1, 1'b1);
      cs_n = 4'b1110;
      wait_cyc(4);
      xfer(8'hF0, 8'h0F, 8);
      wait_cyc(4);
      cs_n = 4'hF;
      wait_cyc(8);
      set_mode(1'b1, 1'b0, 1'b1);
      cs_n = 4'b1110;
      wait_cyc(4);
      xfer(8'hF0, 8'h96, 8);
      wait_cyc(4);
      cs_n = 4'hF;
      wait_cyc(8);
      check("m12_rx_count", 32'(rx_cnt - rb), 2);
      check("m1_mosi",      mosi_q[rb],     8'hF0);
      check("m1_miso",      miso_q[rb],     8'h0F);
      check("m2_mosi",      mosi_q[rb + 1], 8'hF0);
      check("m2_miso",      miso_q[rb + 1], 8'h96);

      // CS released after 5 bits
      rb = rx_cnt; fb = ferr_cnt;
      set_mode(1'b0, 1'b0, 1'b1);
      cs_n = 4'b1110;
      wait_cyc(4);
      xfer(8'hFF, 8'hFF, 5);
      wait_cyc(4);
      check("part_bit_count", bit_count, 5);
      cs_n = 4'hF;
      wait_cyc(8);
      check("part_frame_err", 32'(ferr_cnt - fb), 1);
      check("part_no_rx",     32'(rx_cnt - rb),   0);
      check("part_inactive",  frame_active, 0);
      check("part_cnt_clear", bit_count, 0);

      // Slave select index and multiple selects
      rb = rx_cnt; fb = ferr_cnt; mb = merr_cnt;
      cs_n = 4'b1101;
      wait_cyc(5);
      check("sel_index",  slave_sel,    1);
      check("sel_active", frame_active, 1);
      cs_n = 4'b1100;
      wait_cyc(5);
      check("multi_inactive", frame_active, 0);
      xfer(8'h5A, 8'h5A, 8);
      wait_cyc(4);
      cs_n = 4'hF;
      wait_cyc(8);
      check("multi_err_once", 32'(merr_cnt - mb), 1);
      check("multi_no_rx",    32'(rx_cnt - rb),   0);
      check("multi_no_ferr",  32'(ferr_cnt - fb), 0);

      // areset mid-word, released with CS still low
      rb = rx_cnt; mb = merr_cnt;
      cs_n = 4'b1110;
      wait_cyc(4);
      xfer(8'hC3, 8'hC3, 3);
      areset = 1'b1;
      wait_cyc(1);
      check("arst_frame_active", frame_active, 0);
      check("arst_bit_count",    bit_count,    0);
      check("arst_data",         {mosi_data, miso_data}, 0);
      check("arst_slave_sel",    slave_sel,    0);
      areset = 1'b0;
      wait_cyc(4);
      xfer(8'h77, 8'h77, 8);
      wait_cyc(4);
      check("arst_no_frame",   frame_active, 0);
      check("arst_no_rx",      32'(rx_cnt - rb), 0);
      check("arst_no_merr",    32'(merr_cnt - mb), 0);
      cs_n = 4'hF;
      wait_cyc(6);
      cs_n = 4'b1110;
      wait_cyc(4);
      xfer(8'h3C, 8'hE1, 8);
      wait_cyc(4);
      cs_n = 4'hF;
      wait_cyc(8);
      check("arst_rx_after_toggle", 32'(rx_cnt - rb), 1);
      check("arst_mosi_after",      mosi_q[rb], 8'h3C);
      check("arst_miso_after",      miso_q[rb], 8'hE1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
